// File: rtl/uart_gpio_pkg.sv
// Shared constants and state encodings for the UART-to-GPIO command layer.
package uart_gpio_pkg;

    localparam logic [7:0] CMD_WR_OUT = 8'h01;
    localparam logic [7:0] CMD_WR_DIR = 8'h02;
    localparam logic [7:0] CMD_RD_IN  = 8'h03;
    localparam logic [7:0] CMD_RD_OUT = 8'h04;

    localparam logic [7:0] STATUS_ACK = 8'h5A;
    localparam logic [7:0] STATUS_NAK = 8'hEE;

    typedef enum logic [2:0] {
        HUNT,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        EXEC,
        RESP
    } parser_state_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_BYTE0,
        RS_BYTE1,
        RS_BYTE2
    } resp_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Pushes a 3-byte STATUS, RDATA, STATUS^RDATA response into the TX FIFO,
// stalling on tx_fifo_Full and pulsing done on the final push.
module uart_resp_tx
    import uart_gpio_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] status,
    input  logic [7:0] rdata,
    input  logic       tx_fifo_Full,
    output logic       tx_fifo_writeEn,
    output logic [7:0] tx_fifo_dataIn,
    output logic       done
);

    resp_state_t state, state_next;
    logic [7:0]  status_q;
    logic [7:0]  rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RS_IDLE;
            status_q <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            state <= state_next;
            if (start && state == RS_IDLE) begin
                status_q <= status;
                rdata_q  <= rdata;
            end
        end
    end

    // Each byte state holds its byte on the bus and advances only on a real push.
    always_comb begin
        state_next      = state;
        tx_fifo_writeEn = 1'b0;
        tx_fifo_dataIn  = 8'h00;
        done            = 1'b0;
        case (state)
            RS_IDLE: begin
                if (start) state_next = RS_BYTE0;
            end
            RS_BYTE0: begin
                tx_fifo_dataIn = status_q;
                if (!tx_fifo_Full) begin
                    tx_fifo_writeEn = 1'b1;
                    state_next      = RS_BYTE1;
                end
            end
            RS_BYTE1: begin
                tx_fifo_dataIn = rdata_q;
                if (!tx_fifo_Full) begin
                    tx_fifo_writeEn = 1'b1;
                    state_next      = RS_BYTE2;
                end
            end
            RS_BYTE2: begin
                tx_fifo_dataIn = status_q ^ rdata_q;
                if (!tx_fifo_Full) begin
                    tx_fifo_writeEn = 1'b1;
                    done            = 1'b1;
                    state_next      = RS_IDLE;
                end
            end
            default: state_next = RS_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_gpio_cmd_parser.sv
// Frames SYNC/CMD/DATA/CHK packets from the RX FIFO, executes GPIO register
// accesses and hands an ACK/NAK response to the TX sequencer.
module uart_gpio_cmd_parser
    import uart_gpio_pkg::*;
#(
    parameter int         GPIO_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_fifo_Empty,
    input  logic [7:0]            rx_fifo_dataOut,
    output logic                  rx_fifo_readEn,
    input  logic                  tx_fifo_Full,
    output logic                  tx_fifo_writeEn,
    output logic [7:0]            tx_fifo_dataIn,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_dir,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    parser_state_t         state, state_next;
    logic                  pop_q;
    logic                  byte_valid;
    logic [7:0]            cmd_q, data_q, chk_q;
    logic [TW-1:0]         tmo_cnt;
    logic                  in_frame, can_pop, timeout_hit, resp_done;
    logic                  exec_err;
    logic [7:0]            exec_status, exec_rdata;
    logic [GPIO_WIDTH-1:0] data_masked;

    // A pop is registered so it is held for exactly one cycle; the popped byte
    // is consumed the cycle after, and no new pop starts until that is done.
    assign in_frame       = state inside {GET_CMD, GET_DATA, GET_CHK};
    assign can_pop        = (state == HUNT || in_frame) && !rx_fifo_Empty && !pop_q && !byte_valid;
    assign rx_fifo_readEn = pop_q;
    assign busy           = (state != HUNT);
    assign data_masked    = data_q[GPIO_WIDTH-1:0];
    assign timeout_hit    = in_frame && !byte_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        exec_err    = 1'b1;
        exec_status = STATUS_NAK;
        exec_rdata  = cmd_q;
        if (chk_q == (cmd_q ^ data_q)) begin
            case (cmd_q)
                CMD_WR_OUT, CMD_WR_DIR: begin
                    exec_err    = 1'b0;
                    exec_status = STATUS_ACK;
                    exec_rdata  = 8'(data_masked);
                end
                CMD_RD_IN: begin
                    exec_err    = 1'b0;
                    exec_status = STATUS_ACK;
                    exec_rdata  = 8'(gpio_in);
                end
                CMD_RD_OUT: begin
                    exec_err    = 1'b0;
                    exec_status = STATUS_ACK;
                    exec_rdata  = 8'(gpio_out);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:     if (byte_valid && rx_fifo_dataOut == SYNC_BYTE) state_next = GET_CMD;
            GET_CMD:  if (timeout_hit) state_next = HUNT; else if (byte_valid) state_next = GET_DATA;
            GET_DATA: if (timeout_hit) state_next = HUNT; else if (byte_valid) state_next = GET_CHK;
            GET_CHK:  if (timeout_hit) state_next = HUNT; else if (byte_valid) state_next = EXEC;
            EXEC:     state_next = RESP;
            RESP:     if (resp_done) state_next = HUNT;
            default:  state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            pop_q      <= 1'b0;
            byte_valid <= 1'b0;
            cmd_q      <= 8'h00;
            data_q     <= 8'h00;
            chk_q      <= 8'h00;
            tmo_cnt    <= '0;
            gpio_out   <= '0;
            gpio_dir   <= '0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_next;
            pop_q      <= can_pop;
            byte_valid <= pop_q;

            if (byte_valid) begin
                case (state)
                    GET_CMD:  cmd_q  <= rx_fifo_dataOut;
                    GET_DATA: data_q <= rx_fifo_dataOut;
                    GET_CHK:  chk_q  <= rx_fifo_dataOut;
                    default: ;
                endcase
            end

            // Idle outside the frame so entry to GET_CMD always starts from zero.
            if (byte_valid || !in_frame) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + TW'(1);

            if (state == EXEC && !exec_err) begin
                if (cmd_q == CMD_WR_OUT) gpio_out <= data_masked;
                if (cmd_q == CMD_WR_DIR) gpio_dir <= data_masked;
            end

            if (((state == EXEC && exec_err) || timeout_hit) && err_count != 8'hFF)
                err_count <= err_count + 8'h01;
        end
    end

    uart_resp_tx u_resp_tx (
        .clk             (clk),
        .reset           (reset),
        .start           (state == EXEC),
        .status          (exec_status),
        .rdata           (exec_rdata),
        .tx_fifo_Full    (tx_fifo_Full),
        .tx_fifo_writeEn (tx_fifo_writeEn),
        .tx_fifo_dataIn  (tx_fifo_dataIn),
        .done            (resp_done)
    );

endmodule

// File: tb/tb_uart_gpio_cmd_parser.sv
// Self-checking bench: queue-based RX/TX FIFO models plus a frame-level
// reference model of the command protocol.
module tb_uart_gpio_cmd_parser;

    localparam int TB_TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_fifo_Empty = 1'b1;
    logic [7:0] rx_fifo_dataOut = 8'h00;
    logic       rx_fifo_readEn;
    logic       tx_fifo_Full = 1'b0;
    logic       tx_fifo_writeEn;
    logic [7:0] tx_fifo_dataIn;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;
    logic [7:0] gpio_dir;
    logic       busy;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         push_while_full = 0;
    int         pop_b2b = 0;
    int         rx_underflow = 0;
    logic       prev_rd = 1'b0;

    logic [7:0] m_out = 8'h00;
    logic [7:0] m_dir = 8'h00;
    logic [7:0] m_err = 8'h00;

    uart_gpio_cmd_parser #(
        .GPIO_WIDTH     (8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_fifo_Empty   (rx_fifo_Empty),
        .rx_fifo_dataOut (rx_fifo_dataOut),
        .rx_fifo_readEn  (rx_fifo_readEn),
        .tx_fifo_Full    (tx_fifo_Full),
        .tx_fifo_writeEn (tx_fifo_writeEn),
        .tx_fifo_dataIn  (tx_fifo_dataIn),
        .gpio_in         (gpio_in),
        .gpio_out        (gpio_out),
        .gpio_dir        (gpio_dir),
        .busy            (busy),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    // FIFO models act on the falling edge, where strobes from the last rising edge are stable.
    always @(negedge clk) begin
        if (rx_fifo_readEn) begin
            if (prev_rd) pop_b2b++;
            if (rx_q.size() > 0) rx_fifo_dataOut = rx_q.pop_front();
            else rx_underflow++;
        end
        prev_rd = rx_fifo_readEn;
        if (tx_fifo_writeEn) begin
            tx_q.push_back(tx_fifo_dataIn);
            if (tx_fifo_Full) push_while_full++;
        end
        rx_fifo_Empty = (rx_q.size() == 0);
    end

    // Protocol-level model: one call per complete frame, returns the 3 response bytes.
    function automatic logic [23:0] model_frame(input logic [7:0] cmd, input logic [7:0] data,
                                                input logic [7:0] chk, input logic [7:0] gin);
        logic [7:0] st;
        logic [7:0] rd;
        if (chk != (cmd ^ data) || cmd == 8'h00 || cmd > 8'h04) begin
            st = 8'hEE;
            rd = cmd;
            if (m_err != 8'hFF) m_err = m_err + 8'h01;
        end else begin
            st = 8'h5A;
            case (cmd)
                8'h01:   begin m_out = data; rd = data; end
                8'h02:   begin m_dir = data; rd = data; end
                8'h03:   rd = gin;
                default: rd = m_out;
            endcase
        end
        return {st, rd, st ^ rd};
    endfunction

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
        rx_q.push_back(8'hA5);
        rx_q.push_back(cmd);
        rx_q.push_back(data);
        rx_q.push_back(chk);
    endtask

    task automatic take_resp(output logic [23:0] got, output bit ok);
        ok  = 1'b0;
        got = 24'h0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_q.size() >= 3) begin ok = 1'b1; break; end
        end
        if (ok) begin
            got = {tx_q[0], tx_q[1], tx_q[2]};
            repeat (3) void'(tx_q.pop_front());
        end else begin
            tx_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({gpio_out, gpio_dir, err_count, busy, rx_fifo_readEn, tx_fifo_writeEn, tx_fifo_dataIn} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {gpio_out, gpio_dir, err_count, busy, rx_fifo_readEn, tx_fifo_writeEn, tx_fifo_dataIn});
        end
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_write_out();
        logic [23:0] got;
        bit          ok;
        bit          seen = 1'b0;
        void'(model_frame(8'h01, 8'h3C, 8'h3D, gpio_in));
        applyStimulus(8'h01, 8'h3C, 8'h3D);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = tx_fifo_writeEn;
        end
        checks++;
        if (!seen || gpio_out !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL wr_out_before_ack: got gpio_out=%h seen=%0d required 3c", gpio_out, seen);
        end
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5A3C66) begin errors++; $display("[TB] FAIL wr_out_resp: got %h ok=%0d required 5a3c66", got, ok); end
        checks++;
        if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL wr_out_err: got %h required 00", err_count); end
    endtask

    task automatic test_read_in();
        logic [23:0] got;
        bit          ok;
        gpio_in = 8'h81;
        void'(model_frame(8'h03, 8'h00, 8'h03, gpio_in));
        applyStimulus(8'h03, 8'h00, 8'h03);
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5A81DB) begin errors++; $display("[TB] FAIL rd_in_resp: got %h ok=%0d required 5a81db", got, ok); end
        checks++;
        if ({gpio_out, gpio_dir} !== {8'h3C, 8'h00}) begin
            errors++;
            $display("[TB] FAIL rd_in_regs: got %h required 3c00", {gpio_out, gpio_dir});
        end
    endtask

    task automatic test_bad_checksum();
        logic [23:0] got;
        bit          ok;
        void'(model_frame(8'h02, 8'hFF, 8'h00, gpio_in));
        applyStimulus(8'h02, 8'hFF, 8'h00);
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'hEE02EC) begin errors++; $display("[TB] FAIL bad_chk_resp: got %h ok=%0d required ee02ec", got, ok); end
        checks++;
        if (gpio_dir !== 8'h00 || err_count !== 8'h01) begin
            errors++;
            $display("[TB] FAIL bad_chk_state: got dir=%h err=%h required dir=00 err=01", gpio_dir, err_count);
        end
    endtask

    task automatic test_resync();
        logic [23:0] got;
        bit          ok;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        void'(model_frame(8'h04, 8'h00, 8'h04, gpio_in));
        applyStimulus(8'h04, 8'h00, 8'h04);
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5A3C66) begin errors++; $display("[TB] FAIL resync_resp: got %h ok=%0d required 5a3c66", got, ok); end
        checks++;
        if (err_count !== 8'h01) begin errors++; $display("[TB] FAIL resync_err: got %h required 01", err_count); end
    endtask

    task automatic test_sync_in_payload();
        logic [23:0] got;
        bit          ok;
        void'(model_frame(8'h01, 8'hA5, 8'hA4, gpio_in));
        applyStimulus(8'h01, 8'hA5, 8'hA4);
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5AA5FF || gpio_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL sync_payload: got %h out=%h required 5aa5ff out=a5", got, gpio_out);
        end
    endtask

    task automatic test_timeout();
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h01);
        if (m_err != 8'hFF) m_err = m_err + 8'h01;
        repeat (TB_TIMEOUT - 40) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early: got busy=%b required 1", busy); end
        repeat (80) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || err_count !== m_err || tx_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout_result: got busy=%b err=%h tx=%0d required busy=0 err=%h tx=0",
                     busy, err_count, tx_q.size(), m_err);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] got;
        bit          ok;
        bit          stalled = 1'b1;
        tx_fifo_Full = 1'b1;
        void'(model_frame(8'h01, 8'h5C, 8'h5D, gpio_in));
        applyStimulus(8'h01, 8'h5C, 8'h5D);
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_q.size() != 0) stalled = 1'b0;
        end
        checks++;
        if (!stalled || push_while_full != 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_stall: got tx=%0d pwf=%0d busy=%b required 0 0 1", tx_q.size(), push_while_full, busy);
        end
        tx_fifo_Full = 1'b0;
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5A5C06) begin errors++; $display("[TB] FAIL bp_resp: got %h ok=%0d required 5a5c06", got, ok); end
    endtask

    task automatic test_random_frames();
        logic [23:0] got, exp;
        bit          ok;
        logic [7:0]  cmd, data, chk, b;
        int          r, ng;
        for (int f = 0; f < 30; f++) begin
            gpio_in = 8'($urandom);
            r    = $urandom_range(0, 9);
            cmd  = (r < 8) ? 8'(r % 4 + 1) : 8'($urandom);
            data = 8'($urandom);
            chk  = cmd ^ data;
            if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h11;
                rx_q.push_back(b);
            end
            exp = model_frame(cmd, data, chk, gpio_in);
            applyStimulus(cmd, data, chk);
            take_resp(got, ok);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("[TB] FAIL rand_resp[%0d]: got %h ok=%0d required %h", f, got, ok, exp);
            end
            checks++;
            if ({gpio_out, gpio_dir, err_count} !== {m_out, m_dir, m_err}) begin
                errors++;
                $display("[TB] FAIL rand_regs[%0d]: got %h required %h", f, {gpio_out, gpio_dir, err_count}, {m_out, m_dir, m_err});
            end
        end
        checks++;
        if (pop_b2b != 0 || rx_underflow != 0) begin
            errors++;
            $display("[TB] FAIL rx_handshake: got b2b=%0d underflow=%0d required 0 0", pop_b2b, rx_underflow);
        end
    endtask

    task automatic test_err_saturation();
        logic [23:0] exp_q[$];
        logic [7:0]  data;
        int          bad = 0;
        bit          ok = 1'b0;
        for (int f = 0; f < 260; f++) begin
            data = 8'(f);
            exp_q.push_back(model_frame(8'h02, data, 8'h02 ^ data ^ 8'h01, gpio_in));
            applyStimulus(8'h02, data, 8'h02 ^ data ^ 8'h01);
        end
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (tx_q.size() >= 780);
        end
        for (int f = 0; f < 260 && ok; f++) begin
            if ({tx_q[3*f], tx_q[3*f+1], tx_q[3*f+2]} !== exp_q[f]) bad++;
        end
        tx_q.delete();
        checks++;
        if (!ok || bad != 0) begin errors++; $display("[TB] FAIL sat_stream: got ok=%0d bad=%0d required 1 0", ok, bad); end
        checks++;
        if (err_count !== 8'hFF || gpio_dir !== m_dir) begin
            errors++;
            $display("[TB] FAIL sat_count: got err=%h dir=%h required ff %h", err_count, gpio_dir, m_dir);
        end
    endtask

    task automatic test_reset_mid_response();
        logic [23:0] got;
        bit          ok = 1'b0;
        applyStimulus(8'h02, 8'h0F, 8'h0D);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (tx_q.size() >= 1);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (!ok || {gpio_out, gpio_dir, err_count, busy, rx_fifo_readEn, tx_fifo_writeEn, tx_fifo_dataIn} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %h ok=%0d required 0",
                     {gpio_out, gpio_dir, err_count, busy, rx_fifo_readEn, tx_fifo_writeEn, tx_fifo_dataIn}, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        m_out = 8'h00; m_dir = 8'h00; m_err = 8'h00;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (tx_q.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_push: got tx=%0d busy=%b required 1 0", tx_q.size(), busy);
        end
        tx_q.delete();
        void'(model_frame(8'h01, 8'h77, 8'h76, gpio_in));
        applyStimulus(8'h01, 8'h77, 8'h76);
        take_resp(got, ok);
        checks++;
        if (!ok || got !== 24'h5A772D || gpio_out !== 8'h77 || err_count !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_frame: got %h out=%h err=%h required 5a772d 77 00", got, gpio_out, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_out();
        test_read_in();
        test_bad_checksum();
        test_resync();
        test_sync_in_payload();
        test_timeout();
        test_backpressure();
        test_random_frames();
        test_err_saturation();
        test_reset_mid_response();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_gpio_cmd_parser.md
Name: uart_gpio_cmd_parser

Overview:
Command-layer stage sitting directly downstream of the UART RX FIFO and upstream of the UART TX FIFO. It pops received bytes, frames them into 4-byte GPIO command packets, validates them, and executes register writes or reads on the GPIO output and direction registers. For every accepted frame it pushes a 3-byte ACK or NAK response into the TX FIFO. It is the bridge between the serial link and the GPIO block.

Parameters:
GPIO_WIDTH, 8, number of GPIO pins. Legal range is 1..8. Payload bits above GPIO_WIDTH are ignored on write and read back as 0.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 50000, maximum number of clk cycles allowed between bytes inside a frame.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_fifo_Empty  input  1  RX FIFO empty flag
rx_fifo_dataOut  input  8  RX FIFO read data; valid the cycle after rx_fifo_readEn
rx_fifo_readEn  output  1  one-cycle pop strobe to RX FIFO
tx_fifo_Full  input  1  TX FIFO full flag
tx_fifo_writeEn  output  1  one-cycle push strobe to TX FIFO
tx_fifo_dataIn  output  8  response byte; valid when tx_fifo_writeEn=1
gpio_in  input  GPIO_WIDTH  sampled pin levels (already synchronised)
gpio_out  output  GPIO_WIDTH  output data register
gpio_dir  output  GPIO_WIDTH  direction register, 1=output
busy  output  1  high in every state other than HUNT
err_count  output  8  saturating count of bad frames (checksum error, unknown CMD, timeout)

Behaviour:
- Reset (reset=0, async): every output is 0, FSM goes to HUNT, timeout counter is cleared. A reset mid-frame or mid-response discards the frame and any unsent response bytes.
- Frame format: SYNC_BYTE, CMD, DATA, CHK, with CHK = CMD ^ DATA.
- Commands:
  - 0x01 WR_OUT: gpio_out <= DATA[GPIO_WIDTH-1:0].
  - 0x02 WR_DIR: gpio_dir <= DATA[GPIO_WIDTH-1:0].
  - 0x03 RD_IN: reply with gpio_in, sampled in the EXEC cycle.
  - 0x04 RD_OUT: reply with gpio_out.
- Response format: STATUS, RDATA, STATUS^RDATA.
  - ACK: STATUS=8'h5A. RDATA is the read value, or the masked written value for writes.
  - NAK: STATUS=8'hEE, RDATA=received CMD. Sent on checksum mismatch or unknown CMD; no register changes.
- Byte fetch handshake:
  - Allowed only in HUNT, GET_CMD, GET_DATA and GET_CHK, and only when rx_fifo_Empty=0 and no fetch is pending.
  - Assert rx_fifo_readEn for exactly 1 cycle, then capture rx_fifo_dataOut on the next cycle.
  - Never two pops back-to-back; maximum rate is 1 byte per 2 cycles.
- FSM transitions:
  - HUNT: a captured byte equal to SYNC_BYTE goes to GET_CMD; any other byte is silently dropped (no err_count increment).
  - GET_CMD goes to GET_DATA, which goes to GET_CHK, which goes to EXEC, each on byte capture.
  - A SYNC_BYTE value appearing in CMD, DATA or CHK is treated as ordinary data, not a resync.
  - EXEC (1 cycle): check CHK and decode CMD, apply the register write, latch STATUS/RDATA, go to RESP0.
  - RESP0, RESP1, RESP2: push one byte each. Push only when tx_fifo_Full=0; otherwise stall in place with writeEn=0. After RESP2's push, return to HUNT.
  - No RX pops occur during EXEC or RESP*.
- Timeout: in GET_CMD, GET_DATA or GET_CHK, count cycles since the last capture. When the count reaches TIMEOUT_CYCLES, go to HUNT, increment err_count, and send no response. The counter resets on each capture and on entry to GET_CMD.
- err_count: +1 on NAK or timeout; saturates at 255 and does not wrap.
- Register write timing: the write is visible on gpio_out/gpio_dir the cycle after EXEC, before the ACK bytes are pushed.

Decomposition:
- Shared package uart_gpio_pkg holds:
  - command codes CMD_WR_OUT, CMD_WR_DIR, CMD_RD_IN and CMD_RD_OUT;
  - STATUS_ACK and STATUS_NAK;
  - the FSM state enum.
- The response sequencer (RESP0..RESP2 plus tx_fifo handshake) is a natural sub-module: uart_resp_tx. It takes STATUS/RDATA plus a start strobe and returns done.
- Everything else, including the RX fetch handshake, stays in one module.

Test Plan:
- Write output: feed A5 01 3C 3D into the RX FIFO -> gpio_out=8'h3C one cycle after EXEC; TX receives 5A 3C 66; err_count=0.
- Read input: with gpio_in=8'h81, feed A5 03 00 03 -> TX receives 5A 81 DB; gpio_out and gpio_dir unchanged.
- Bad checksum: feed A5 02 FF 00 -> gpio_dir unchanged; TX receives EE 02 EC; err_count=1.
- Resync and garbage: feed 11 22 A5 04 00 04 -> 11 and 22 are dropped silently; with gpio_out=3C, TX receives 5A 3C 66; err_count unchanged.
- Timeout and backpressure:
  - Feed A5 01 then wait TIMEOUT_CYCLES -> HUNT, err_count+1, no TX push.
  - Then send a valid frame with tx_fifo_Full held high for 20 cycles -> writeEn stays 0 while Full is high, and all 3 bytes arrive in order once Full drops.
- Reset mid-response: assert reset during RESP1 -> all outputs 0 immediately, no further TX pushes, and the next valid frame is processed normally.
